// File: rtl/sfx_pkg.sv
// Shared types and constants for the sound-effect voice mixer.
package sfx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2
    } mix_state_t;

    // Each voice's gain field is an arithmetic right shift of 0..3.
    localparam int GAIN_W = 2;

    function automatic longint sat_hi(input int out_w);
        return (longint'(1) <<< (out_w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_lo(input int out_w);
        return -(longint'(1) <<< (out_w - 1));
    endfunction

endpackage

// File: rtl/sfx_voice_ctrl.sv
// One voice: trigger edge capture, pending restart flag, clip position and active flag.
module sfx_voice_ctrl #(
    parameter int ADDR_W    = 12,
    parameter int VOICE_LEN = 4096
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              trigger,
    input  logic              loop_en,
    input  logic              update,
    output logic              active,
    output logic [ADDR_W-1:0] pos
);

    logic trigger_q;
    logic pending;
    logic trigger_rise;

    assign trigger_rise = trigger & ~trigger_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            trigger_q <= 1'b0;
            pending   <= 1'b0;
            active    <= 1'b0;
            pos       <= '0;
        end else begin
            trigger_q <= trigger;
            // An edge arriving in the update cycle itself survives into the next frame.
            pending   <= trigger_rise | (pending & ~update);
            if (update) begin
                if (pending) begin
                    pos    <= '0;
                    active <= 1'b1;
                end else if (active && pos == ADDR_W'(VOICE_LEN - 1)) begin
                    pos    <= '0;
                    active <= loop_en;
                end else if (active) begin
                    pos <= pos + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sfx_voice_mixer.sv
// Time-multiplexed voice fetch, gain scaling and saturating mix; one sample per frame
// to the audio controller. Handshake: a write happens in the OUT cycle where audio_out_allowed=1.
module sfx_voice_mixer
    import sfx_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 8,
    parameter int OUT_W      = 16,
    parameter int ADDR_W     = 12,
    parameter int VOICE_LEN  = 4096,
    localparam int VIDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                         CLOCK_50,
    input  logic                         resetn,
    input  logic [NUM_VOICES-1:0]        trigger,
    input  logic [NUM_VOICES-1:0]        loop_en,
    input  logic [GAIN_W*NUM_VOICES-1:0] gain,
    input  logic                         mute,
    output logic [VIDX_W+ADDR_W-1:0]     rom_addr,
    input  logic [SAMPLE_W-1:0]          rom_data,
    input  logic                         audio_out_allowed,
    output logic                         write_audio_out,
    output logic [OUT_W-1:0]             audio_out,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [1:0]                   state_dbg
);

    localparam int K_W      = $clog2(NUM_VOICES + 1);
    localparam int ACC_W    = OUT_W + $clog2(NUM_VOICES) + 1;
    localparam int SHIFT_UP = OUT_W - SAMPLE_W;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_hi(OUT_W));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_lo(OUT_W));

    mix_state_t state, state_next;
    logic [K_W-1:0]            k;
    logic signed [ACC_W-1:0]   acc, acc_next, contrib;
    logic signed [SAMPLE_W-1:0] rom_sample;
    logic signed [OUT_W-1:0]   sample_ext, scaled;
    logic [GAIN_W-1:0]         cur_gain;
    logic                      cur_active;
    logic [OUT_W-1:0]          sat_val;
    logic [ADDR_W-1:0]         voice_pos [NUM_VOICES];

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        sfx_voice_ctrl #(.ADDR_W(ADDR_W), .VOICE_LEN(VOICE_LEN)) u_voice (
            .CLOCK_50 (CLOCK_50),
            .resetn   (resetn),
            .trigger  (trigger[g]),
            .loop_en  (loop_en[g]),
            .update   (write_audio_out),
            .active   (voice_active[g]),
            .pos      (voice_pos[g])
        );
    end

    assign write_audio_out = (state == OUT) && audio_out_allowed;
    assign state_dbg       = state;
    assign rom_sample      = rom_data;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (audio_out_allowed) state_next = FETCH;
            FETCH:   if (k == K_W'(NUM_VOICES)) state_next = OUT;
            OUT:     if (audio_out_allowed) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rom_addr = '0;
        if (state == FETCH) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (k == K_W'(i)) rom_addr = {VIDX_W'(i), voice_pos[i]};
            end
        end
    end

    // rom_data in slot k belongs to the address issued in slot k-1.
    always_comb begin
        cur_gain   = '0;
        cur_active = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (k == K_W'(i + 1)) begin
                cur_gain   = gain[GAIN_W*i +: GAIN_W];
                cur_active = voice_active[i];
            end
        end
        sample_ext = OUT_W'(rom_sample);
        scaled     = sample_ext <<< SHIFT_UP;
        scaled     = scaled >>> cur_gain;
        contrib    = cur_active ? ACC_W'(scaled) : '0;
        acc_next   = (k != '0) ? acc + contrib : acc;
        if (acc_next > SAT_HI)      sat_val = SAT_HI[OUT_W-1:0];
        else if (acc_next < SAT_LO) sat_val = SAT_LO[OUT_W-1:0];
        else                        sat_val = acc_next[OUT_W-1:0];
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            k         <= '0;
            acc       <= '0;
            audio_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (audio_out_allowed) begin
                        k   <= '0;
                        acc <= '0;
                    end
                end
                FETCH: begin
                    acc <= acc_next;
                    k   <= k + K_W'(1);
                    // Latched on OUT entry so the sample is stable through any stall.
                    if (k == K_W'(NUM_VOICES)) audio_out <= mute ? '0 : sat_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sfx_voice_mixer.sv
// Scoreboard bench for sfx_voice_mixer: a behavioural voice/ROM model predicts each written sample.
module tb_sfx_voice_mixer;

    localparam int NV = 4;
    localparam int SW = 8;
    localparam int OW = 16;
    localparam int AW = 12;
    localparam int VL = 4096;
    localparam int SH = OW - SW;

    logic            clk = 1'b0;
    logic            resetn;
    logic [NV-1:0]   trigger;
    logic [NV-1:0]   loop_en;
    logic [2*NV-1:0] gain;
    logic            mute;
    logic [AW+1:0]   rom_addr;
    logic [SW-1:0]   rom_data = '0;
    logic            allowed;
    logic            write;
    logic [OW-1:0]   audio_out;
    logic [NV-1:0]   voice_active;
    logic [1:0]      state_dbg;

    always #5 clk = ~clk;

    sfx_voice_mixer #(
        .NUM_VOICES(NV), .SAMPLE_W(SW), .OUT_W(OW), .ADDR_W(AW), .VOICE_LEN(VL)
    ) dut (
        .CLOCK_50          (clk),
        .resetn            (resetn),
        .trigger           (trigger),
        .loop_en           (loop_en),
        .gain              (gain),
        .mute              (mute),
        .rom_addr          (rom_addr),
        .rom_data          (rom_data),
        .audio_out_allowed (allowed),
        .write_audio_out   (write),
        .audio_out         (audio_out),
        .voice_active      (voice_active),
        .state_dbg         (state_dbg)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int m_pos [NV];
    bit m_act [NV];
    bit m_pend[NV];
    int rom_mode [NV];
    int rom_const[NV];
    logic [OW-1:0] exp_q[$];

    bit chk_next = 1'b0;
    bit per_chk  = 1'b0;
    bit have_prev = 1'b0;
    int cyc = 0;
    int prev_cyc = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int rom_val(input int v, input int p);
        return (rom_mode[v] != 0) ? (p % 127) + 1 : rom_const[v];
    endfunction

    function automatic int model_mix();
        int s = 0;
        for (int v = 0; v < NV; v++)
            if (m_act[v]) s += (rom_val(v, m_pos[v]) * (1 << SH)) >>> gain[2*v +: 2];
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return mute ? 0 : s;
    endfunction

    function automatic int model_act_vec();
        int r = 0;
        for (int v = 0; v < NV; v++) if (m_act[v]) r |= (1 << v);
        return r;
    endfunction

    task automatic model_update();
        for (int v = 0; v < NV; v++) begin
            if (m_pend[v]) begin
                m_pos[v] = 0; m_act[v] = 1'b1; m_pend[v] = 1'b0;
            end else if (m_act[v] && m_pos[v] == VL - 1) begin
                m_pos[v] = 0; m_act[v] = loop_en[v];
            end else if (m_act[v]) begin
                m_pos[v]++;
            end
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_pos[v] = 0; m_act[v] = 1'b0; m_pend[v] = 1'b0;
        end
        exp_q.delete();
        chk_next  = 1'b0;
        have_prev = 1'b0;
    endtask

    always @(posedge clk)
        rom_data <= SW'(rom_val(int'(rom_addr[AW +: 2]), int'(rom_addr[AW-1:0])));

    // Push the predicted sample at the strobe, pop it one cycle later while audio_out is held.
    always @(negedge clk) begin
        logic [OW-1:0] e;
        #2;
        cyc++;
        if (resetn) begin
            if (chk_next) begin
                e = exp_q.pop_front();
                check("audio_out_held", int'($signed(audio_out)), int'($signed(e)));
                check("voice_active", int'(voice_active), model_act_vec());
                chk_next = 1'b0;
            end
            if (write) begin
                exp_q.push_back(OW'(model_mix()));
                check("audio_out_strobe", int'($signed(audio_out)), int'($signed(exp_q[0])));
                model_update();
                if (per_chk && have_prev) check("period", cyc - prev_cyc, NV + 3);
                prev_cyc  = cyc;
                have_prev = 1'b1;
                chk_next  = 1'b1;
            end
        end
    end

    task automatic wait_write();
        int n = 0;
        do begin @(negedge clk); n++; end while (!write && n < 40);
        if (!write) check("write_timeout", 0, 1);
    endtask

    task automatic next_frame();
        wait_write();
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) next_frame();
    endtask

    task automatic trig(input logic [NV-1:0] mask);
        trigger = mask;
        for (int v = 0; v < NV; v++) if (mask[v]) m_pend[v] = 1'b1;
        @(negedge clk);
        trigger = '0;
    endtask

    task automatic latency_check();
        int n = 0;
        allowed = 1'b1;
        do begin @(negedge clk); n++; end while (!write && n < 20);
        check("latency", n, NV + 2);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_write"}, int'(write), 0);
        check({tag, "_audio"}, int'(audio_out), 0);
        check({tag, "_active"}, int'(voice_active), 0);
        check({tag, "_rom_addr"}, int'(rom_addr), 0);
    endtask

    initial begin
        resetn = 1'b0; allowed = 1'b0; trigger = '0; loop_en = '0; gain = '0; mute = 1'b0;
        for (int v = 0; v < NV; v++) begin rom_mode[v] = 0; rom_const[v] = 0; end
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        repeat (4) begin @(negedge clk); check("idle_no_write", int'(write), 0); end
        latency_check();

        // Single voice, constant 64, full clip.
        rom_const[0] = 64;
        trig(4'b0001);
        next_frame();
        per_chk = 1'b1;
        frames(VL);
        check("clip_last_audio", int'($signed(audio_out)), 16384);
        check("clip_end_active0", int'(voice_active[0]), 0);
        next_frame();
        check("after_clip_audio", int'($signed(audio_out)), 0);
        per_chk = 1'b0;

        // Reset in the middle of a fetch.
        trig(4'b0001);
        frames(3);
        @(negedge clk);
        @(negedge clk);
        #3 resetn = 1'b0;
        #1 check_reset_outputs("midframe_reset");
        model_reset();
        allowed = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) begin @(negedge clk); check("post_reset_no_write", int'(write), 0); end
        latency_check();

        // Saturation, all four voices.
        loop_en = 4'b0010;
        for (int v = 0; v < NV; v++) rom_const[v] = 127;
        trig(4'b1111);
        next_frame();
        next_frame();
        check("sat_hi", int'($signed(audio_out)), 32767);
        for (int v = 0; v < NV; v++) rom_const[v] = -128;
        next_frame();
        check("sat_lo", int'($signed(audio_out)), -32768);

        // Gain and mute.
        for (int v = 0; v < NV; v++) rom_const[v] = 0;
        rom_const[0] = 64;
        gain = 8'b0000_0010;
        next_frame();
        check("gain2", int'($signed(audio_out)), 4096);
        mute = 1'b1;
        rom_mode[0] = 1;
        frames(3);
        check("mute", int'($signed(audio_out)), 0);
        mute = 1'b0;
        next_frame();

        // Handshake stall in OUT.
        @(negedge clk);
        allowed = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check("stall_no_write", int'(write), 0);
            if (c >= 5) check("stall_hold", int'($signed(audio_out)), model_mix());
        end
        check("stall_state", int'(state_dbg), 2);
        allowed = 1'b1;
        #1 check("stall_release", int'(write), 1);
        @(negedge clk);

        // Loop wrap on voice 1.
        rom_mode[0] = 0;
        rom_const[0] = 0;
        rom_mode[1] = 1;
        gain = '0;
        for (int n = 0; n < 5000 && m_pos[1] != VL - 1; n++) next_frame();
        check("wrap_reached", m_pos[1], VL - 1);
        next_frame();
        next_frame();
        check("wrap_audio", int'($signed(audio_out)), 256);
        check("wrap_active", int'(voice_active), 4'b0010);

        // Retrigger at position 100.
        for (int n = 0; n < 200 && m_pos[1] != 100; n++) next_frame();
        check("retrig_reached", m_pos[1], 100);
        trig(4'b0010);
        next_frame();
        check("retrig_pos100", int'($signed(audio_out)), 25856);
        next_frame();
        check("retrig_pos0", int'($signed(audio_out)), 256);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
